pipelined_adder: RTL and testbench

- Parametrised, pipelined ripple-carry adder/subtractor; successor to the team's fixed 8-bit combinational ripple adder.
- Splits a WIDTH-bit add into STAGES equal chunks, one chunk per pipeline stage, with the carry registered between stages.
- valid/ready handshake on both sides, so it can sit between streaming datapath blocks with back-pressure.
- Adds per-transaction subtract mode and signed-overflow reporting.

---
 rtl/pipelined_adder_pkg.sv | 11 +
 rtl/pipelined_adder_chunk.sv | 28 ++
 rtl/pipelined_adder.sv | 112 +++++++++++
 tb/tb_pipelined_adder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared constants and configuration check for the pipelined adder/subtractor.
package pipelined_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;

    function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry slice; also exposes the carry into its top bit.
module adder_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage,
// carry registered between stages, valid/ready on both sides.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter  int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter  int unsigned STAGES = DEFAULT_STAGES,
    localparam int unsigned CHUNK  = WIDTH / STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    // c holds the carry into the next chunk; cm the carry into the current top bit.
    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             cm;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t              st_q [STAGES];
    logic [STAGES-1:0]   vld;
    logic [STAGES:0]     rdy;

    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int unsigned i = STAGES; i > 0; i--) begin
            rdy[i-1] = !vld[i-1] || rdy[i];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           src;
        stage_t           stg_d;
        stage_t           stg_q;
        logic [CHUNK-1:0] ch_s;
        logic             ch_co;
        logic             ch_cm;

        // Stage 0 sees the raw operands; its carry field doubles as the effective carry-in.
        if (k == 0) begin : g_head
            always_comb begin
                src    = '0;
                src.v  = in_valid;
                src.c  = sub | cin;
                src.a  = a;
                src.b  = b ^ {WIDTH{sub}};
            end
        end else begin : g_body
            assign src = st_q[k-1];
        end

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a     (src.a[k*CHUNK +: CHUNK]),
            .b     (src.b[k*CHUNK +: CHUNK]),
            .ci    (src.c),
            .s     (ch_s),
            .co    (ch_co),
            .c_msb (ch_cm)
        );

        always_comb begin
            stg_d                     = src;
            stg_d.s[k*CHUNK +: CHUNK] = ch_s;
            stg_d.a[k*CHUNK +: CHUNK] = '0;
            stg_d.b[k*CHUNK +: CHUNK] = '0;
            stg_d.c                   = ch_co;
            stg_d.cm                  = ch_cm;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stg_q <= '0;
            end else if (rdy[k]) begin
                if (src.v) begin
                    stg_q <= stg_d;
                end else begin
                    stg_q.v <= 1'b0;
                end
            end
        end

        assign st_q[k] = stg_q;
        assign vld[k]  = stg_q.v;
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES-1];
    assign sum       = st_q[STAGES-1].s;
    assign cout      = st_q[STAGES-1].c;
    assign ovf       = st_q[STAGES-1].c ^ st_q[STAGES-1].cm;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: vector table on an 8/2 instance, scoreboard on a 32/4 instance.
module tb_pipelined_adder;

    localparam int unsigned S8  = 2;
    localparam int unsigned S32 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;

    logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32, cout32, ovf32;
    logic [31:0] a32, b32, sum32;

    pipelined_adder #(.WIDTH(8), .STAGES(S8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(S32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32), .out_valid(out_valid32),
        .out_ready(out_ready32), .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain wide addition; overflow from operand/result sign bits.
    function automatic logic [33:0] ref32(input logic [31:0] ra, input logic [31:0] rb,
                                          input logic rcin, input logic rsub);
        logic [31:0] bb;
        logic [32:0] full;
        logic        ov;
        bb   = rsub ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, bb} + {32'd0, (rsub ? 1'b1 : rcin)};
        ov   = (ra[31] == bb[31]) && (full[31] != ra[31]);
        return {ov, full[32], full[31:0]};
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
    } beat_t;

    beat_t         beats[$];
    logic [33:0]   exp_q[$];
    int unsigned   cyc_q[$];
    int unsigned   cyc      = 0;
    int unsigned   out_cnt  = 0;
    bit            chk_lat  = 0;
    bit            prev_stall = 0;
    logic [33:0]   prev_out;
    logic [33:0]   exp_e;
    int unsigned   exp_c;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", {out_valid32, ovf32, cout32, sum32}, {1'b1, prev_out});
            end
            if (out_valid32 && out_ready32) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got 0x%0h expected no result", {ovf32, cout32, sum32});
                end else begin
                    exp_e = exp_q.pop_front();
                    exp_c = cyc_q.pop_front();
                    check("sb_result", {ovf32, cout32, sum32}, exp_e);
                    if (chk_lat) check("sb_latency", cyc - exp_c, S32);
                    out_cnt++;
                end
            end
            if (in_valid32 && in_ready32) begin
                exp_q.push_back(ref32(a32, b32, cin32, sub32));
                cyc_q.push_back(cyc);
            end
            prev_stall = out_valid32 && !out_ready32;
            prev_out   = {ovf32, cout32, sum32};
        end
    end

    // mode: 0 out_ready low, 1 out_ready high, 2 random out_ready. Entered and left at posedge+1.
    task automatic run32(input int unsigned max_cyc, input int unsigned mode, input bit until_empty);
        for (int unsigned c = 0; c < max_cyc; c++) begin
            if (until_empty && beats.size() == 0 && exp_q.size() == 0) break;
            if (beats.size() > 0) begin
                in_valid32 = 1'b1;
                a32        = beats[0].a;
                b32        = beats[0].b;
                cin32      = beats[0].cin;
                sub32      = beats[0].sub;
            end else begin
                in_valid32 = 1'b0;
            end
            case (mode)
                0:       out_ready32 = 1'b0;
                1:       out_ready32 = 1'b1;
                default: out_ready32 = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (in_valid32 && in_ready32) void'(beats.pop_front());
            @(posedge clk);
            #1;
        end
        in_valid32 = 1'b0;
    endtask

    task automatic add_random_beats(input int unsigned n);
        beat_t bt;
        for (int unsigned i = 0; i < n; i++) begin
            bt.a   = $urandom;
            bt.b   = $urandom;
            bt.cin = 1'($urandom_range(0, 1));
            bt.sub = 1'($urandom_range(0, 1));
            beats.push_back(bt);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec8_t;

    vec8_t vecs[10];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat;
        int unsigned base;
        beat_t       bt;

        vecs[0] = '{8'h6A, 8'hBD, 1'b0, 1'b0, 8'h27, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[9] = '{8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};

        in_valid8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0; out_ready8 = 1;
        in_valid32 = 0; a32 = '0; b32 = '0; cin32 = 0; sub32 = 0; out_ready32 = 1;

        repeat (2) @(posedge clk);
        #1;
        check("rst8_out_valid", out_valid8, 0);
        check("rst8_sum", sum8, 0);
        check("rst8_cout", cout8, 0);
        check("rst8_ovf", ovf8, 0);
        check("rst8_in_ready", in_ready8, 1);
        check("rst32_out_valid", out_valid32, 0);
        check("rst32_sum", sum32, 0);
        check("rst32_cout", cout32, 0);
        check("rst32_ovf", ovf32, 0);
        check("rst32_in_ready", in_ready32, 1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Directed vectors, 8-bit / 2-stage; latency counted from the cycle the beat is presented.
        for (int unsigned i = 0; i < 10; i++) begin
            a8 = vecs[i].a; b8 = vecs[i].b; cin8 = vecs[i].cin; sub8 = vecs[i].sub;
            in_valid8 = 1;
            check($sformatf("v8_%0d_in_ready", i), in_ready8, 1);
            @(posedge clk);
            #1;
            in_valid8 = 0;
            lat = 1;
            while (!out_valid8 && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("v8_%0d_latency", i), lat, S8);
            check($sformatf("v8_%0d_sum", i), sum8, vecs[i].sum);
            check($sformatf("v8_%0d_cout", i), cout8, vecs[i].cout);
            check($sformatf("v8_%0d_ovf", i), ovf8, vecs[i].ovf);
            @(posedge clk);
            #1;
        end

        // Back-pressure: six beats against a stalled output.
        base = out_cnt;
        add_random_beats(6);
        run32(8, 0, 0);
        check("bp_accepted_before_full", beats.size(), 2);
        check("bp_in_ready_low", in_ready32, 0);
        check("bp_out_valid_held", out_valid32, 1);
        run32(40, 1, 1);
        check("bp_drain_beats", beats.size(), 0);
        check("bp_drain_queue", exp_q.size(), 0);
        check("bp_out_count", out_cnt - base, 6);

        // Full rate: one accept per cycle, fixed latency.
        base = out_cnt;
        chk_lat = 1;
        add_random_beats(100);
        run32(100, 1, 0);
        check("fr_all_accepted", beats.size(), 0);
        run32(20, 1, 1);
        chk_lat = 0;
        check("fr_drain_queue", exp_q.size(), 0);
        check("fr_out_count", out_cnt - base, 100);

        // Random output stalls.
        base = out_cnt;
        add_random_beats(60);
        run32(600, 2, 1);
        check("rs_drain_beats", beats.size(), 0);
        check("rs_drain_queue", exp_q.size(), 0);
        check("rs_out_count", out_cnt - base, 60);

        // Reset with three beats in flight.
        bt = '{32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0};
        beats.push_back(bt);
        bt = '{32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0};
        beats.push_back(bt);
        bt = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1};
        beats.push_back(bt);
        run32(5, 0, 0);
        check("rf_pre_out_valid", out_valid32, 1);
        #2;
        rst_n = 0;
        #1;
        check("rf_out_valid", out_valid32, 0);
        check("rf_sum", sum32, 0);
        check("rf_cout", cout32, 0);
        check("rf_ovf", ovf32, 0);
        check("rf_in_ready", in_ready32, 1);
        exp_q.delete();
        cyc_q.delete();
        beats.delete();
        @(negedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        base = out_cnt;
        bt = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
        beats.push_back(bt);
        run32(20, 1, 1);
        run32(8, 1, 0);
        check("rf_post_queue", exp_q.size(), 0);
        check("rf_post_out_count", out_cnt - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
